// File: rtl/packet_switch_sfw_pkt_fifo.sv
// packet_switch_sfw_pkt_fifo: store-and-forward packet FIFO with commit/rewind write side and FWFT read side
module packet_switch_sfw_pkt_fifo #(
    parameter int DW = 64,
    parameter int DEPTH = 512,
    parameter int AFULL_THRESH = DEPTH - 16,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [AW:0]      used,
    output logic [AW:0]      pkt_cnt,
    output logic             afull,
    output logic             drop,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] PONE = (AW+1)'(1);
    typedef enum logic [1:0] {IDLE, PKT, DISCARD} state_t;
    state_t state, state_n;
    logic [AW:0] wptr, cptr, rptr, fptr, wptr_n, cptr_n, w_addr;
    logic w_en, commit, drop_n, full, full_c;
    logic [DW+1:0] mem [DEPTH];
    logic [DW+1:0] rd_q;
    logic rd_v, rd_en, load_out, accept, eop_rd;
    assign used = wptr - rptr;
    assign full = used == FULL;
    assign full_c = (cptr - rptr) == FULL;
    // A new sop always starts at cptr: outside PKT wptr already equals cptr, inside PKT it rewinds
    always_comb begin
        state_n = state;
        wptr_n = wptr;
        cptr_n = cptr;
        w_addr = wptr;
        w_en = 1'b0;
        commit = 1'b0;
        drop_n = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                drop_n = (state == PKT) || full_c || (in_eop && in_err);
                wptr_n = cptr;
                if (full_c || (in_eop && in_err)) begin
                    state_n = in_eop ? IDLE : DISCARD;
                end else begin
                    w_en = 1'b1;
                    w_addr = cptr;
                    wptr_n = cptr + PONE;
                    commit = in_eop;
                    cptr_n = in_eop ? cptr + PONE : cptr;
                    state_n = in_eop ? IDLE : PKT;
                end
            end else if (state == PKT) begin
                if (full || (in_eop && in_err)) begin
                    drop_n = 1'b1;
                    wptr_n = cptr;
                    state_n = (!full || in_eop) ? IDLE : DISCARD;
                end else begin
                    w_en = 1'b1;
                    wptr_n = wptr + PONE;
                    commit = in_eop;
                    cptr_n = in_eop ? wptr + PONE : cptr;
                    state_n = in_eop ? IDLE : PKT;
                end
            end else if (state == DISCARD && in_eop) begin
                state_n = IDLE;
            end
        end
    end
    assign accept = out_valid && out_ready;
    assign eop_rd = accept && out_eop;
    assign load_out = rd_v && (!out_valid || out_ready);
    assign rd_en = (fptr != cptr) && (!rd_v || load_out);
    always_ff @(posedge clk) begin
        if (w_en) mem[w_addr[AW-1:0]] <= {in_sop, in_eop, in_data};
        if (rd_en) rd_q <= mem[fptr[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wptr <= '0;
            cptr <= '0;
            rptr <= '0;
            fptr <= '0;
            rd_v <= 1'b0;
            out_valid <= 1'b0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            out_data <= '0;
            pkt_cnt <= '0;
            afull <= 1'b0;
            drop <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            wptr <= wptr_n;
            cptr <= cptr_n;
            if (rd_en) fptr <= fptr + PONE;
            if (accept) rptr <= rptr + PONE;
            rd_v <= rd_en || (rd_v && !load_out);
            out_valid <= load_out || (out_valid && !out_ready);
            if (load_out) {out_sop, out_eop, out_data} <= rd_q;
            pkt_cnt <= (commit && !eop_rd) ? pkt_cnt + PONE : (!commit && eop_rd) ? pkt_cnt - PONE : pkt_cnt;
            afull <= used >= AF;
            drop <= drop_n;
            if (drop_n && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/packet_switch_sfw_pkt_fifo.md
# packet_switch_sfw_pkt_fifo

Packet-aware store-and-forward FIFO for the packet switch datapath, replacing the plain pointer-release FIFO on ingress and egress buffering paths. Beats are written speculatively and become visible to the read side only when the packet's end-of-packet beat commits error-free. Errored, truncated or overflowing packets are rewound and dropped in place. Width, depth and almost-full threshold are parametrised, and the output uses a valid/ready handshake.

## Interface
- DW, 64, payload width in bits
- DEPTH, 512, beat storage; power of 2, at least 8; AW = $clog2(DEPTH)
- AFULL_THRESH, DEPTH-16, `afull` asserts when used beats >= this value
- CNT_W, 16, width of the saturating drop counter
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  write beat valid (no backpressure; the block never stalls the writer)
- in_data  in  DW  write payload
- in_sop  in  1  first beat of a packet
- in_eop  in  1  last beat of a packet
- in_err  in  1  sampled on the eop beat; 1 drops the packet
- out_valid  out  1  read beat valid
- out_ready  in  1  read-side accept
- out_data  out  DW  read payload
- out_sop  out  1  read beat is the first beat of a packet
- out_eop  out  1  read beat is the last beat of a packet
- used  out  AW+1  beats written (committed and speculative) and not yet read
- pkt_cnt  out  AW+1  committed packets whose eop has not yet been read
- afull  out  1  `used` >= AFULL_THRESH (registered)
- drop  out  1  one-cycle pulse per dropped packet
- drop_cnt  out  CNT_W  saturating count of dropped packets

## Operation
- Storage holds DEPTH entries of {sop, eop, data}, DW+2 bits wide. Pointers are AW+1 bits: write pointer `wptr`, commit pointer `cptr`, read pointer `rptr`.
- Write side is a state machine:
  - IDLE: wait for an sop beat; non-sop beats are ignored and not counted.
  - PKT: accept beats.
  - DISCARD: swallow beats through the next eop.
- IDLE + (in_valid & in_sop):
  - Write the beat at wptr; wptr += 1.
  - If in_eop is also set, this is a single-beat packet and commits immediately.
  - Otherwise go to PKT.
- PKT + in_valid, normal beat: write at wptr; wptr += 1. If in_eop & !in_err: cptr <= wptr+1, pkt_cnt += 1, go to IDLE.
- PKT + eop with in_err: wptr <= cptr, drop pulse, go to IDLE. The eop beat is not written.
- PKT + in_sop (missing eop): rewind wptr to cptr, drop pulse, then treat the new sop beat as an IDLE start in the same cycle. The new beat is written at the old cptr.
- Overflow: any beat arriving with wptr - rptr == DEPTH.
  - Rewind wptr to cptr and pulse drop.
  - If the overflowing beat is not an eop, go to DISCARD; if it is an eop, go to IDLE.
  - An overflowing sop in IDLE follows the same rule; nothing is written.
- DISCARD: ignore everything until an eop beat, then go to IDLE. An sop seen in DISCARD restarts as an IDLE sop; no additional drop pulse is issued.
- drop_cnt increments on each drop pulse and saturates at all-ones.
- Read side:
  - Data is readable when rptr != cptr.
  - One-entry prefetch output register, first-word-fall-through style.
  - out_* are held stable while out_valid & !out_ready.
- pkt_cnt decrements when a beat with out_eop is accepted. A commit and an eop-read in the same cycle leave pkt_cnt unchanged.
- used = wptr - rptr is computed combinationally from the registered pointers. An accepted read frees space from the next cycle.
- Wrap-around uses the natural modulo-2^(AW+1) pointer arithmetic. Full and empty are distinguished by the pointer MSB.

## Timing
- Reset values:
  - out_valid=0, out_sop=0, out_eop=0, out_data=0
  - used=0, pkt_cnt=0, afull=0, drop=0, drop_cnt=0
  - all pointers 0; write FSM in IDLE
- Reset mid-packet discards all contents, committed and speculative.
- Commit latency: an eop accepted at edge N updates cptr at N. The first beat of that packet's read can show out_valid at N+2, after the registered RAM read plus prefetch.
- Read throughput is one beat per cycle with out_ready held high. There are no bubbles between back-to-back committed packets.
- Write throughput is one beat per cycle unconditionally.
- drop asserts in the cycle after the offending beat is sampled, for exactly one cycle.
- afull is registered, so it lags `used` by one cycle.

## Test plan
- 4-beat packet (sop at beat 0, eop at beat 3, err=0) with out_ready=1: out_valid rises 2 cycles after the eop; 4 beats emerge with data intact; pkt_cnt goes 0->1->0; drop_cnt=0.
- 3-beat packet with in_err=1 on its eop, followed by a good 2-beat packet: only the 2 good beats emerge; drop_cnt=1; used returns to 0.
- DEPTH=8, out_ready=0: write a 6-beat good packet, then a 4-beat packet. The 3rd beat of the second packet overflows, so drop pulses once. After releasing out_ready, exactly 6 beats are read out.
- Packet with a missing eop (sop, 2 beats, new sop, eop): one drop is counted; only the 2-beat second packet is read.
- Wrap test, DEPTH=8: 20 back-to-back 3-beat packets with random out_ready. All 60 beats arrive in order with no loss, and pointers wrap at least twice.
- Simultaneous commit and eop-read with pkt_cnt=1: pkt_cnt stays at 1. Separately, assert rst mid-packet: all outputs return to their reset values on the next cycle.
